meas_frame_fifo: RTL and testbench

//  Downstream of the acquisition sequencer: buffers measurement results (two ADC words plus a mode/mux tag)
//  and emits them as framed byte packets over a valid/ready byte stream toward the host link.
//  The sequencer writes one record per measurement; the host link drains bytes at its own pace.

---
 rtl/meas_frame_fifo_pkg.sv | 12 +
 rtl/meas_frame_fifo_if.sv | 27 ++
 rtl/meas_frame_fifo_sync_fifo.sv | 47 ++++
 rtl/meas_frame_fifo.sv | 78 +++++++
 tb/tb_meas_frame_fifo.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/meas_frame_fifo_pkg.sv
// meas_frame_fifo_pkg: framing constants and FSM state type shared by the frame FIFO files.
package meas_frame_fifo_pkg;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int SEQ_W = 4;
    localparam int TAG_W = 4;
    localparam logic [TAG_W-1:0] TAG_MODE_SINGLE = 4'h1;
    localparam logic [TAG_W-1:0] TAG_MODE_DIFF = 4'h2;
    typedef enum logic {ST_IDLE, ST_SEND} state_t;
    function automatic int frame_len(input int data_width);
        return 3 + 2 * (data_width / 8);
    endfunction
endpackage

// File: rtl/meas_frame_fifo_if.sv
// meas_frame_fifo_if: record write port, FIFO status and output byte stream of the frame FIFO.
interface meas_frame_fifo_if #(
    parameter int DATA_WIDTH = 24,
    parameter int TAG_WIDTH = 4,
    parameter int DEPTH_LOG2 = 4
);
    logic clear;
    logic wr_en;
    logic [TAG_WIDTH-1:0] wr_tag;
    logic [DATA_WIDTH-1:0] wr_data_1;
    logic [DATA_WIDTH-1:0] wr_data_2;
    logic full;
    logic empty;
    logic [DEPTH_LOG2:0] level;
    logic overflow;
    logic [7:0] out_byte;
    logic out_valid;
    logic out_ready;
    modport master (
        output clear, wr_en, wr_tag, wr_data_1, wr_data_2, out_ready,
        input full, empty, level, overflow, out_byte, out_valid
    );
    modport slave (
        input clear, wr_en, wr_tag, wr_data_1, wr_data_2, out_ready,
        output full, empty, level, overflow, out_byte, out_valid
    );
endinterface

// File: rtl/meas_frame_fifo_sync_fifo.sv
// sync_fifo: register-array FIFO with registered full/empty/level; writes while full are ignored.
module sync_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic o_full,
    output logic o_empty,
    output logic [DEPTH_LOG2:0] o_level
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0] r_level, w_level_nxt;
    logic r_full, r_empty;
    logic w_push, w_pop;
    assign w_push = i_wr_en && !r_full;
    assign w_pop = i_rd_en && !r_empty;
    assign w_level_nxt = r_level + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
    assign o_dout = r_mem[r_rd_ptr];
    assign o_full = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level <= '0;
            r_full <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full <= w_level_nxt == (DEPTH_LOG2+1)'(DEPTH);
            r_empty <= w_level_nxt == '0;
        end
    end
endmodule

// File: rtl/meas_frame_fifo.sv
// meas_frame_fifo: buffers {seq, tag, data_1, data_2} records and streams them as
// sync / seq-tag / data_1 / data_2 / XOR-checksum byte frames over valid/ready.
module meas_frame_fifo
    import meas_frame_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int TAG_WIDTH = TAG_W,
    parameter int DEPTH_LOG2 = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input logic clk,
    input logic rst,
    meas_frame_fifo_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int FL = frame_len(DATA_WIDTH);
    localparam int RW = SEQ_W + TAG_WIDTH + 2 * DATA_WIDTH;
    localparam int IW = $clog2(FL);
    state_t r_state, w_state_nxt;
    logic [RW-1:0] r_shadow, w_head;
    logic [IW-1:0] r_idx;
    logic [SEQ_W-1:0] r_seq;
    logic r_overflow;
    logic w_hs, w_last, w_pop;
    logic [7:0] w_frame [FL];
    logic [7:0] w_csum;
    sync_fifo #(.WIDTH(RW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk(clk),
        .rst(rst),
        .i_clear(bus.clear),
        .i_wr_en(bus.wr_en),
        .i_din({r_seq, bus.wr_tag, bus.wr_data_1, bus.wr_data_2}),
        .i_rd_en(w_pop),
        .o_dout(w_head),
        .o_full(bus.full),
        .o_empty(bus.empty),
        .o_level(bus.level)
    );
    assign w_hs = r_state == ST_SEND && bus.out_ready;
    assign w_last = r_idx == IW'(FL - 1);
    // Popping after the checksum handshake keeps consecutive frames gap-free.
    assign w_pop = !bus.clear && !bus.empty && (r_state == ST_IDLE || (w_hs && w_last));
    assign bus.overflow = r_overflow;
    always_ff @(posedge clk)
        r_state <= rst ? ST_IDLE : w_state_nxt;
    always_comb
        w_state_nxt = bus.clear ? ST_IDLE : w_pop ? ST_SEND : (w_hs && w_last) ? ST_IDLE : r_state;
    always_comb begin
        bus.out_valid = r_state == ST_SEND;
        bus.out_byte = bus.out_valid ? w_frame[r_idx] : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_shadow <= '0;
            r_idx <= '0;
            r_seq <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shadow <= w_head;
                r_idx <= '0;
            end else if (w_hs && !w_last) r_idx <= r_idx + 1'b1;
            if (bus.wr_en && !bus.full) r_seq <= r_seq + 1'b1;
            if (bus.wr_en && bus.full) r_overflow <= 1'b1;
        end
    end
    // data_1 and data_2 sit adjacent in the shadow, so both words are one MSB-first byte run.
    always_comb begin
        w_frame[0] = SYNC_BYTE;
        w_frame[1] = r_shadow[RW-1 -: 8];
        w_csum = r_shadow[RW-1 -: 8];
        for (int i = 0; i < 2 * NB; i++) begin
            w_frame[2+i] = r_shadow[2*DATA_WIDTH-1-8*i -: 8];
            w_csum = w_csum ^ r_shadow[2*DATA_WIDTH-1-8*i -: 8];
        end
        w_frame[FL-1] = w_csum;
    end
endmodule

// File: tb/tb_meas_frame_fifo.sv
// tb_meas_frame_fifo: directed checks of framing, back-pressure, overflow, clear and reset.
module tb_meas_frame_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int nexp = 0;
    logic [7:0] exp_b [256];
    logic [3:0] mseq = 4'd0;
    meas_frame_fifo_if bus ();
    meas_frame_fifo dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] t, input logic [23:0] a, input logic [23:0] b);
        bus.wr_en = 1'b1;
        bus.wr_tag = t;
        bus.wr_data_1 = a;
        bus.wr_data_2 = b;
        tick;
        bus.wr_en = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        exp_b[nexp] = b;
        nexp++;
    endtask

    function automatic logic [7:0] fb(input logic [3:0] s, input logic [3:0] t,
                                      input logic [23:0] a, input logic [23:0] b, input int i);
        logic [7:0] x [9];
        x = '{8'hA5, {s, t}, a[23:16], a[15:8], a[7:0], b[23:16], b[15:8], b[7:0], 8'h00};
        x[8] = x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
        return x[i];
    endfunction

    task automatic add_frame(input logic [3:0] s, input logic [3:0] t,
                             input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < 9; i++) put(fb(s, t, a, b, i));
    endtask

    // Drains exp_b[0..nexp-1]; strict demands out_valid on every cycle.
    task automatic recv(input logic [31:0] pat, input bit strict);
        int k = 0;
        int c = 0;
        logic stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        while (k < nexp && c < 400) begin
            bus.out_ready = pat[c % 32];
            if (stalled) check("stall_hold", {bus.out_valid, bus.out_byte}, {1'b1, prev});
            if (strict) check("contig_valid", bus.out_valid, 1);
            if (bus.out_valid) check($sformatf("byte%0d", k), bus.out_byte, exp_b[k]);
            stalled = bus.out_valid && !bus.out_ready;
            prev = bus.out_byte;
            if (bus.out_valid && bus.out_ready) k++;
            tick;
            c++;
        end
        check("recv_count", k, nexp);
        nexp = 0;
        bus.out_ready = 1'b0;
    endtask

    task automatic fill;
        for (int i = 0; i < 18; i++) begin
            wr(4'(i + 3), 24'h13579B + 24'(i), 24'hC0FFEE ^ 24'(i));
            if (i < 17) begin
                add_frame(mseq, 4'(i + 3), 24'h13579B + 24'(i), 24'hC0FFEE ^ 24'(i));
                mseq++;
            end
            if (i == 15) begin
                check("fill_level15", bus.level, 15);
                check("fill_notfull", bus.full, 0);
            end
            if (i == 16) begin
                check("fill_level16", bus.level, 16);
                check("fill_full", bus.full, 1);
                check("fill_no_ovf", bus.overflow, 0);
            end
        end
        check("ovf_set", bus.overflow, 1);
        check("ovf_level", bus.level, 16);
        check("inflight_valid", bus.out_valid, 1);
        check("inflight_sync", bus.out_byte, 8'hA5);
    endtask

    task automatic clear_pulse;
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        mseq = 4'd0;
    endtask

    initial begin
        bus.clear = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_tag = '0;
        bus.wr_data_1 = '0;
        bus.wr_data_2 = '0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_full", bus.full, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_level", bus.level, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_byte", bus.out_byte, 0);

        wr(4'h1, 24'h123456, 24'hABCDEF);
        check("s1_level", bus.level, 1);
        check("s1_novalid", bus.out_valid, 0);
        tick;
        check("s1_valid_n2", bus.out_valid, 1);
        check("s1_sync_n2", bus.out_byte, 8'hA5);
        check("s1_popped", bus.level, 0);
        put(8'hA5); put(8'h01); put(8'h12); put(8'h34); put(8'h56);
        put(8'hAB); put(8'hCD); put(8'hEF); put(8'hF8);
        recv(32'hFFFF_FFFF, 1'b1);
        check("s1_idle", bus.out_valid, 0);
        check("s1_empty", bus.empty, 1);

        wr(4'h1, 24'h123456, 24'hABCDEF);
        put(8'hA5); put(8'h11); put(8'h12); put(8'h34); put(8'h56);
        put(8'hAB); put(8'hCD); put(8'hEF); put(8'hE8);
        recv(32'hB2D5_3A6C, 1'b0);
        check("s2_idle", bus.out_valid, 0);

        clear_pulse;
        fill;
        recv(32'hFFFF_FFFF, 1'b1);
        check("s3_empty", bus.empty, 1);
        check("s3_idle", bus.out_valid, 0);
        check("s3_ovf_sticky", bus.overflow, 1);

        clear_pulse;
        check("clr_ovf", bus.overflow, 0);
        for (int i = 0; i < 3; i++) begin
            wr(4'(9 - i), 24'hA00000 + 24'(i * 16), 24'h0F0F0F ^ 24'(i));
            add_frame(mseq, 4'(9 - i), 24'hA00000 + 24'(i * 16), 24'h0F0F0F ^ 24'(i));
            mseq++;
        end
        recv(32'hFFFF_FFFF, 1'b1);
        check("s4_idle", bus.out_valid, 0);

        clear_pulse;
        fill;
        nexp = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        check("s5_idx4", bus.out_byte, 8'h9B);
        bus.clear = 1'b1;
        wr(4'hE, 24'hDEAD00, 24'h00BEEF);
        bus.clear = 1'b0;
        bus.out_ready = 1'b0;
        check("s5_valid", bus.out_valid, 0);
        check("s5_byte", bus.out_byte, 0);
        check("s5_level", bus.level, 0);
        check("s5_empty", bus.empty, 1);
        check("s5_full", bus.full, 0);
        check("s5_ovf", bus.overflow, 0);
        wr(4'h7, 24'h000000, 24'h000000);
        tick;
        check("s5_sync", bus.out_byte, 8'hA5);
        put(8'hA5); put(8'h07); put(8'h00); put(8'h00); put(8'h00);
        put(8'h00); put(8'h00); put(8'h00); put(8'h07);
        recv(32'hFFFF_FFFF, 1'b1);
        check("s5_idle", bus.out_valid, 0);

        for (int i = 0; i < 3; i++) wr(4'h5, 24'h555555, 24'h333333);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("s6_full", bus.full, 0);
        check("s6_empty", bus.empty, 1);
        check("s6_level", bus.level, 0);
        check("s6_ovf", bus.overflow, 0);
        check("s6_valid", bus.out_valid, 0);
        check("s6_byte", bus.out_byte, 0);
        for (int i = 0; i < 3; i++) tick;
        check("s6_quiet", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        wr(4'h2, 24'h000001, 24'h000000);
        tick;
        put(8'hA5); put(8'h02); put(8'h00); put(8'h00); put(8'h01);
        put(8'h00); put(8'h00); put(8'h00); put(8'h03);
        recv(32'hFFFF_FFFF, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
